// File: rtl/stall_controller_pkg.sv
// Shared definitions for the hazard stall/flush sequencer: FSM encoding and
// default multiplier timing.
package stall_controller_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   localparam int MUL_LATENCY_DEFAULT = 4;
   localparam int CNT_W_DEFAULT       = 3;

endpackage

// File: rtl/stall_controller_if.sv
// Hazard-unit signal bundle: pipeline hazard inputs and stall/flush/multiplier
// controls. The pipeline side is master, the sequencer is slave.
interface stall_controller_if;

   logic Match_12D_E;
   logic MemtoRegE;
   logic PCWrPendingF;
   logic PCSrcW;
   logic BranchTakenE;
   logic MulStartE;

   logic StallF;
   logic StallD;
   logic StallE;
   logic FlushD;
   logic FlushE;
   logic BubbleM;
   logic MulGo;
   logic MulValidE;
   logic MulKill;
   logic MulBusy;

   modport master (
      output Match_12D_E, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE, MulStartE,
      input  StallF, StallD, StallE, FlushD, FlushE, BubbleM,
      input  MulGo, MulValidE, MulKill, MulBusy
   );

   modport slave (
      input  Match_12D_E, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE, MulStartE,
      output StallF, StallD, StallE, FlushD, FlushE, BubbleM,
      output MulGo, MulValidE, MulKill, MulBusy
   );

endinterface

// File: rtl/stall_controller_mulcycle_counter.sv
// Down-counter tracking the remaining multiply stall cycles; loads on start,
// decrements on request, flags zero. Never wraps.
module mulcycle_counter #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/stall_controller.sv
// Five-stage pipeline stall/flush sequencer: load-use, PC-write and branch
// hazards plus scheduling of the fixed-latency Execute-stage multiplier.
module stall_controller
   import stall_controller_pkg::*;
#(
   parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   stall_controller_if.slave  hz
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LATENCY - 2);

   state_t state, state_nxt;
   logic   cnt_zero;
   logic   mul_start, mul_abort, mul_dec;

   assign mul_start = (state == ST_IDLE) && hz.MulStartE;
   assign mul_abort = (state == ST_BUSY) && hz.PCSrcW;
   assign mul_dec   = (state == ST_BUSY) && !hz.PCSrcW && !cnt_zero;

   mulcycle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (mul_start),
      .load_val (LOAD_VAL),
      .dec      (mul_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Abort beats completion: a PC write in Writeback squashes the multiply.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (hz.MulStartE)             state_nxt = ST_BUSY;
         ST_BUSY: if (hz.PCSrcW || cnt_zero)    state_nxt = ST_IDLE;
         default:                               state_nxt = ST_IDLE;
      endcase
   end

   logic mul_stall, ldr_stall, stall_d, mul_go, mul_valid, mul_kill;

   always_comb begin
      mul_stall = 1'b0;
      mul_go    = 1'b0;
      mul_valid = 1'b0;
      mul_kill  = 1'b0;
      ldr_stall = 1'b0;
      stall_d   = 1'b0;
      hz.StallF    = 1'b0;
      hz.StallD    = 1'b0;
      hz.StallE    = 1'b0;
      hz.FlushD    = 1'b0;
      hz.FlushE    = 1'b0;
      hz.BubbleM   = 1'b0;
      hz.MulGo     = 1'b0;
      hz.MulValidE = 1'b0;
      hz.MulKill   = 1'b0;
      hz.MulBusy   = 1'b0;
      if (!reset) begin
         case (state)
            ST_IDLE: begin
               mul_go    = hz.MulStartE;
               mul_stall = hz.MulStartE;
            end
            ST_BUSY: begin
               mul_kill  = hz.PCSrcW;
               mul_valid = !hz.PCSrcW && cnt_zero;
               mul_stall = !hz.PCSrcW && !cnt_zero;
            end
            default: ;
         endcase
         ldr_stall = hz.Match_12D_E && hz.MemtoRegE;
         stall_d   = ldr_stall || mul_stall;

         hz.StallF    = ldr_stall || hz.PCWrPendingF || mul_stall;
         hz.StallD    = stall_d;
         hz.StallE    = mul_stall;
         hz.BubbleM   = mul_stall;
         hz.FlushD    = (hz.PCWrPendingF || hz.PCSrcW || hz.BranchTakenE) && !stall_d;
         hz.FlushE    = ldr_stall || hz.BranchTakenE || mul_kill;
         hz.MulGo     = mul_go;
         hz.MulValidE = mul_valid;
         hz.MulKill   = mul_kill;
         hz.MulBusy   = (state == ST_BUSY);
      end
   end

endmodule
